regfile_param: RTL

- Parametrised successor to the processor's 32x32 register file: configurable width and depth, two registered read ports and one write port.
- Read and write are both allowed in the same cycle, with write-to-read bypass.
- After reset, a sequencer clears the array one entry per cycle; `busy` is high until the clear completes.
- Sits in the decode stage, feeding ALU operands; `busy` stalls the fetch/decode control until the file is clear.

---
 rtl/regfile_param.sv | 129 ++++++++++++
 1 files changed

// File: rtl/regfile_param.sv
// Parametrised register file: two registered read ports, one write port, write-to-read bypass,
// and a post-reset clear sequencer. Optional macro REGFILE_R0_ZERO_EN hardwires register 0 to zero.
module regfile_param #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] readaddr1,
  input  logic [ADDR_W-1:0] readaddr2,
  input  logic              re1,
  input  logic              re2,
  output logic [DATA_W-1:0] readdata1,
  output logic [DATA_W-1:0] readdata2,
  input  logic [ADDR_W-1:0] writeaddr,
  input  logic [DATA_W-1:0] writedata,
  input  logic              RegWrite,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_V  = (ADDR_W+1)'(DEPTH - 1);
`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W:0]   clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd_val1_p0;
  logic [DATA_W-1:0] rd_val2_p0;
  logic              run_p0;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_V;
  endfunction

  function automatic logic is_r0(input logic [ADDR_W-1:0] a);
    return R0_ZERO && (a == '0);
  endfunction

  function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
    return a[IDX_W-1:0];
  endfunction

  // Bypass takes priority over stored data; unmapped addresses and a hardwired r0 read as zero.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] ra,
    input logic [DATA_W-1:0] stored,
    input logic              wr,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd
  );
    if (!in_range(ra) || is_r0(ra)) return '0;
    if (wr && (wa == ra))           return wd;
    return stored;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_CLEAR;
      clr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_CLEAR) clr_ptr <= clr_ptr + (ADDR_W+1)'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: if (clr_ptr == LAST_V) state_nxt = S_RUN;
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_CLEAR;
    endcase
  end

  always_comb begin
    busy   = (state == S_CLEAR);
    run_p0 = (state == S_RUN) && !reset;
  end

  // Single array write port shared between the clear sequencer and the user write.
  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = '0;
    mem_wdata = '0;
    if (!reset && (state == S_CLEAR)) begin
      mem_we  = 1'b1;
      mem_idx = clr_ptr[IDX_W-1:0];
    end else if (run_p0 && RegWrite && in_range(writeaddr) && !is_r0(writeaddr)) begin
      mem_we    = 1'b1;
      mem_idx   = idx(writeaddr);
      mem_wdata = writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= mem_wdata;
  end

  always_comb begin
    rd_val1_p0 = read_port(readaddr1, mem[idx(readaddr1)], RegWrite, writeaddr, writedata);
    rd_val2_p0 = read_port(readaddr2, mem[idx(readaddr2)], RegWrite, writeaddr, writedata);
  end

  // Stage p0 -> registered read outputs
  always_ff @(posedge clk) begin
    if (reset || (state == S_CLEAR)) begin
      readdata1 <= '0;
      readdata2 <= '0;
    end else begin
      if (re1) readdata1 <= rd_val1_p0;
      if (re2) readdata2 <= rd_val2_p0;
    end
  end

endmodule
